// File: rtl/thread_fetch_pc.sv
// -----------------------------------------------------------------------------
// thread_fetch_pc
//
// Program-counter generator and thread selector for the two-thread core. Holds
// one fetch PC per thread and picks which thread fetches each cycle. Threads are
// interleaved round-robin. It can optionally switch away from a thread stalled
// for too long. Drives the fetch address straight into the i-cache.
//
// Ports:
//   clk           clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   stall         fetch stall from hazard control; current thread holds
//   thread_en     per-thread run enable (bit i = thread i)
//   redirect_we   load-PC write enable
//   redirect_pc   load-PC new address (low two bits dropped)
//   redirect_tid  load-PC target thread
//   pred_valid    branch prediction valid for the PC currently driven
//   pred_taken    prediction outcome, 1 = taken
//   pred_target   predicted target (low two bits dropped)
//   pred_tid      thread the prediction belongs to
//   pc            fetch address
//   pc_tid        fetch thread
//   pc_valid      fetch address is a real fetch (current thread enabled)
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module thread_fetch_pc #(
    parameter int unsigned              ADDR_WIDTH          = `ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC0           = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC1           = 32'h0000_1000,
    parameter int unsigned              SWITCH_STALL_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic [1:0]            thread_en,
    input  logic                  redirect_we,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_tid,
    input  logic                  pred_valid,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  pred_tid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_tid,
    output logic                  pc_valid
);

    // Stall count at which the switch fires (count of earlier stalled edges).
    localparam logic [7:0] SWITCH_LAST = 8'(SWITCH_STALL_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] pc_r   [2];
    logic [ADDR_WIDTH-1:0] pc_nxt [2];
    logic                  cur_tid;
    logic                  tid_nxt;
    logic [7:0]            stall_cnt;
    logic [7:0]            cnt_nxt;

    logic advance;
    logic pred_hit;
    logic redirect_cur;
    logic other_en;

    assign pc       = pc_r[cur_tid];
    assign pc_tid   = cur_tid;
    assign pc_valid = thread_en[cur_tid];

    assign advance      = pc_valid & ~stall;
    assign pred_hit     = pred_valid & pred_taken & (pred_tid == cur_tid);
    assign redirect_cur = redirect_we & (redirect_tid == cur_tid);
    assign other_en     = thread_en[~cur_tid];

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        pc_nxt[0] = pc_r[0];
        pc_nxt[1] = pc_r[1];
        tid_nxt   = cur_tid;
        cnt_nxt   = stall_cnt;

        if (advance) begin
            pc_nxt[cur_tid] = pred_hit ? (pred_target & ALIGN_MASK)
                                       : pc_r[cur_tid] + ADDR_WIDTH'(4);
        end

        // Redirect is applied last so it overrides advance/prediction on the
        // same thread, while leaving the other thread's advance untouched.
        if (redirect_we) begin
            pc_nxt[redirect_tid] = redirect_pc & ALIGN_MASK;
        end

        if (advance || !pc_valid) begin
            // Normal thread select; also moves off a thread that was disabled.
            if (other_en) begin
                tid_nxt = ~cur_tid;
            end
            cnt_nxt = '0;
        end else begin
            // Stalled on a live thread.
            if (SWITCH_STALL_CYCLES == 0 || redirect_cur) begin
                // A redirect to the stalled thread gives it a fresh start.
                cnt_nxt = '0;
            end else if (stall_cnt == SWITCH_LAST && other_en) begin
                // Abandon the stalled thread; its PC is refetched later.
                tid_nxt = ~cur_tid;
                cnt_nxt = '0;
            end else if (stall_cnt != 8'hFF) begin
                cnt_nxt = stall_cnt + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values. The two-entry PC array is reset explicitly
    // because each thread must start at a defined address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r[0]   <= RESET_PC0;
            pc_r[1]   <= RESET_PC1;
            cur_tid   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pc_r[0]   <= pc_nxt[0];
            pc_r[1]   <= pc_nxt[1];
            cur_tid   <= tid_nxt;
            stall_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_thread_fetch_pc.sv
// -----------------------------------------------------------------------------
// tb_thread_fetch_pc
//
// Directed bench for thread_fetch_pc (built with SWITCH_STALL_CYCLES = 3).
// A behavioural model tracks both thread PCs, the selected thread and the stall
// count, and is compared with the DUT on every falling edge. Directed steps also
// check hand-computed literal values one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_thread_fetch_pc;

    localparam int SW = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  thread_en;
    logic        redirect_we;
    logic [31:0] redirect_pc;
    logic        redirect_tid;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_tid;
    logic [31:0] pc;
    logic        pc_tid;
    logic        pc_valid;

    int checks = 0;
    int errors = 0;

    thread_fetch_pc #(
        .ADDR_WIDTH          (32),
        .RESET_PC0           (32'h0000_0000),
        .RESET_PC1           (32'h0000_1000),
        .SWITCH_STALL_CYCLES (SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .thread_en    (thread_en),
        .redirect_we  (redirect_we),
        .redirect_pc  (redirect_pc),
        .redirect_tid (redirect_tid),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .pred_tid     (pred_tid),
        .pc           (pc),
        .pc_tid       (pc_tid),
        .pc_valid     (pc_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0][31:0] pc;
        logic             tid;
        int               cnt;
    } model_t;

    model_t m;

    function automatic model_t next_model(input model_t s);
        model_t n        = s;
        bit     live     = thread_en[s.tid];
        bit     other_on = thread_en[!s.tid];
        if (live && !stall) begin
            if (pred_valid && pred_taken && pred_tid == s.tid)
                n.pc[s.tid] = pred_target & ~32'd3;
            else
                n.pc[s.tid] = s.pc[s.tid] + 32'd4;
            if (other_on) n.tid = !s.tid;
            n.cnt = 0;
        end else if (!live) begin
            if (other_on) n.tid = !s.tid;
            n.cnt = 0;
        end else begin
            if (redirect_we && redirect_tid == s.tid) n.cnt = 0;
            else if (s.cnt == SW - 1 && other_on) begin
                n.tid = !s.tid;
                n.cnt = 0;
            end else n.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
        end
        if (redirect_we) n.pc[redirect_tid] = redirect_pc & ~32'd3;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m.pc[0] <= 32'h0000_0000;
            m.pc[1] <= 32'h0000_1000;
            m.tid   <= 1'b0;
            m.cnt   <= 0;
        end else begin
            m <= next_model(m);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_pc",       pc,       m.pc[m.tid]);
        check("cyc_pc_tid",   pc_tid,   m.tid);
        check("cyc_pc_valid", pc_valid, thread_en[m.tid]);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] epc, input logic etid, input logic evalid);
        check({name, "_pc"},    pc,       epc);
        check({name, "_tid"},   pc_tid,   etid);
        check({name, "_valid"}, pc_valid, evalid);
    endtask

    logic [31:0] rr_pc  [8] = '{32'h1000, 32'h4, 32'h1004, 32'h8, 32'h1008, 32'hC, 32'h100C, 32'h10};
    logic        rr_tid [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b1; stall = 1'b0; thread_en = 2'b01;
        redirect_we = 1'b0; redirect_pc = '0; redirect_tid = 1'b0;
        pred_valid = 1'b0; pred_taken = 1'b0; pred_target = '0; pred_tid = 1'b0;
        #2 rst_n = 1'b0;
        #1 expect_out("reset", 32'h0, 1'b0, 1'b1);
        #9 rst_n = 1'b1;

        // Single thread sequence 0x0 -> 0x4 -> 0x8.
        tick(); expect_out("single1", 32'h4, 1'b0, 1'b1);
        tick(); expect_out("single2", 32'h8, 1'b0, 1'b1);

        // Taken prediction for this thread.
        pred_valid = 1'b1; pred_taken = 1'b1; pred_target = 32'h40; pred_tid = 1'b0;
        tick(); expect_out("pred_taken", 32'h40, 1'b0, 1'b1);
        pred_valid = 1'b0;
        // Redirect overrides the normal advance.
        redirect_we = 1'b1; redirect_pc = 32'h8; redirect_tid = 1'b0;
        tick(); check("redir_adv", pc, 32'h8);
        redirect_we = 1'b0;
        // Prediction tagged for the other thread is ignored.
        pred_valid = 1'b1; pred_taken = 1'b1; pred_target = 32'h40; pred_tid = 1'b1;
        tick(); check("pred_wrong_tid", pc, 32'hC);
        // Redirect beats a same-thread prediction; address aligned.
        pred_tid = 1'b0; redirect_we = 1'b1; redirect_pc = 32'h203; redirect_tid = 1'b0;
        tick(); check("redir_vs_pred", pc, 32'h200);
        redirect_we = 1'b0; pred_taken = 1'b0;
        tick(); check("pred_not_taken", pc, 32'h204);
        pred_taken = 1'b1; pred_target = 32'h47;
        tick(); check("pred_align", pc, 32'h44);
        pred_valid = 1'b0;

        // Stall holds the PC; redirect mid-stall lands next cycle.
        stall = 1'b1;
        tick(); check("stall1", pc, 32'h44);
        tick(); check("stall2", pc, 32'h44);
        redirect_we = 1'b1; redirect_pc = 32'h80; redirect_tid = 1'b0;
        tick(); check("stall_redir", pc, 32'h80);
        redirect_we = 1'b0;
        tick(); check("stall4", pc, 32'h80);
        tick(); expect_out("stall5", 32'h80, 1'b0, 1'b1);
        stall = 1'b0;
        tick(); check("unstall", pc, 32'h84);

        // Wrap at the top of the address space.
        redirect_we = 1'b1; redirect_pc = 32'hFFFF_FFFF; redirect_tid = 1'b0;
        tick(); check("wrap_load", pc, 32'hFFFF_FFFC);
        redirect_we = 1'b0;
        tick(); check("wrap", pc, 32'h0);
        thread_en = 2'b11;
        tick(); expect_out("pre_reset", 32'h1000, 1'b1, 1'b1);

        // Mid-run reset is immediate; a redirect during reset is dropped.
        rst_n = 1'b0;
        #1 expect_out("reset_mid", 32'h0, 1'b0, 1'b1);
        redirect_we = 1'b1; redirect_pc = 32'h500; redirect_tid = 1'b0;
        tick(); check("reset_redir", pc, 32'h0);
        redirect_we = 1'b0;
        #2 rst_n = 1'b1;
        expect_out("rr0", 32'h0, 1'b0, 1'b1);

        // Round-robin interleaving up to thread 0 at 0x10.
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out($sformatf("rr%0d", i + 1), rr_pc[i], rr_tid[i], 1'b1);
        end

        // Switch on stall after three stalled edges.
        stall = 1'b1; redirect_we = 1'b1; redirect_pc = 32'h1000; redirect_tid = 1'b1;
        tick(); expect_out("sos1", 32'h10, 1'b0, 1'b1);
        redirect_we = 1'b0;
        tick(); expect_out("sos2", 32'h10, 1'b0, 1'b1);
        tick(); expect_out("sos3", 32'h1000, 1'b1, 1'b1);
        stall = 1'b0;
        tick(); expect_out("resume", 32'h10, 1'b0, 1'b1);
        tick(); expect_out("resume1", 32'h1004, 1'b1, 1'b1);

        // Disabling the current thread drops pc_valid at once.
        thread_en = 2'b01;
        #1 check("dis_valid", pc_valid, 1'b0);
        tick(); expect_out("dis_move", 32'h14, 1'b0, 1'b1);
        thread_en = 2'b00;
        #1 check("none_valid", pc_valid, 1'b0);
        tick(); expect_out("none_hold", 32'h14, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
